// File: rtl/pipe_pkg.sv
// Shared types for the pipeline stage register: occupancy encoding and the NOP control word.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

    localparam int unsigned CTRL_MAX_W = 64;
    localparam logic [CTRL_MAX_W-1:0] CTRL_NOP = '0;

endpackage

// File: rtl/pipe_slot.sv
// One stage entry: payload, control and valid, with load, clear-to-NOP and masked payload zeroing.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int unsigned       DATA_W    = 128,
    parameter int unsigned       CTRL_W    = 10,
    parameter logic [DATA_W-1:0] ZERO_MASK = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic              mask_zero,
    input  logic [DATA_W-1:0] load_data,
    input  logic [CTRL_W-1:0] load_ctrl,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl
);

    // Clear wins over load; unmasked payload bits keep their value when cleared.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
            ctrl  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            ctrl  <= CTRL_W'(CTRL_NOP);
            if (mask_zero) begin
                data <= data & ~ZERO_MASK;
            end
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            ctrl  <= load_ctrl;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush-to-NOP and an optional 2-entry skid buffer.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned       DATA_W    = 128,
    parameter int unsigned       CTRL_W    = 10,
    parameter logic [DATA_W-1:0] ZERO_MASK = '0,
    parameter bit                SKID      = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    occ_t state_q;
    occ_t state_d;

    logic              head_valid;
    logic [DATA_W-1:0] head_data;
    logic [CTRL_W-1:0] head_ctrl;
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;

    logic              in_fire;
    logic              out_fire;
    logic              head_load;
    logic              head_clear;
    logic              head_from_skid;
    logic              skid_load;
    logic              skid_clear;
    logic              squash;
    logic [DATA_W-1:0] head_load_data;
    logic [CTRL_W-1:0] head_load_ctrl;

    // In skid mode ready comes straight from the skid slot's valid flop (full == TWO).
    always_comb begin
        if (reset) begin
            in_ready = 1'b0;
        end else if (flush) begin
            in_ready = 1'b1;
        end else if (SKID) begin
            in_ready = !skid_valid;
        end else begin
            in_ready = !head_valid | out_ready;
        end
    end

    assign in_fire  = in_valid & in_ready;
    assign out_fire = head_valid & out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        head_load      = 1'b0;
        head_clear     = 1'b0;
        head_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        squash         = 1'b0;
        if (flush) begin
            state_d    = EMPTY;
            head_clear = 1'b1;
            skid_clear = 1'b1;
            squash     = 1'b1;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        head_load = 1'b1;
                        state_d   = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        head_load = 1'b1;
                    end else if (in_fire) begin
                        skid_load = 1'b1;
                        state_d   = TWO;
                    end else if (out_fire) begin
                        head_clear = 1'b1;
                        state_d    = EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        head_load      = 1'b1;
                        head_from_skid = 1'b1;
                        skid_clear     = 1'b1;
                        state_d        = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    assign head_load_data = head_from_skid ? skid_data : in_data;
    assign head_load_ctrl = head_from_skid ? skid_ctrl : in_ctrl;

    pipe_slot #(
        .DATA_W    (DATA_W),
        .CTRL_W    (CTRL_W),
        .ZERO_MASK (ZERO_MASK)
    ) u_head (
        .clk       (clk),
        .reset     (reset),
        .load      (head_load),
        .clear     (head_clear),
        .mask_zero (squash),
        .load_data (head_load_data),
        .load_ctrl (head_load_ctrl),
        .valid     (head_valid),
        .data      (head_data),
        .ctrl      (head_ctrl)
    );

    if (SKID) begin : g_skid
        pipe_slot #(
            .DATA_W    (DATA_W),
            .CTRL_W    (CTRL_W),
            .ZERO_MASK (ZERO_MASK)
        ) u_skid (
            .clk       (clk),
            .reset     (reset),
            .load      (skid_load),
            .clear     (skid_clear),
            .mask_zero (squash),
            .load_data (in_data),
            .load_ctrl (in_ctrl),
            .valid     (skid_valid),
            .data      (skid_data),
            .ctrl      (skid_ctrl)
        );
    end else begin : g_no_skid
        logic unused_skid;
        assign skid_valid  = 1'b0;
        assign skid_data   = '0;
        assign skid_ctrl   = '0;
        assign unused_skid = skid_load ^ skid_clear;
    end

    assign out_valid = head_valid;
    assign out_data  = head_data;
    assign out_ctrl  = head_ctrl;
    assign occupancy = state_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid instance and a flow-through instance share stimulus, each with its own scoreboard.
module tb_pipe_stage_reg;

    localparam int unsigned   DW   = 16;
    localparam int unsigned   CW   = 10;
    localparam logic [DW-1:0] MASK = 16'hFF00;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          out_ready;

    logic          s_in_ready, s_out_valid;
    logic [DW-1:0] s_out_data;
    logic [CW-1:0] s_out_ctrl;
    logic [1:0]    s_occ;
    logic          f_in_ready, f_out_valid;
    logic [DW-1:0] f_out_data;
    logic [CW-1:0] f_out_ctrl;
    logic [1:0]    f_occ;

    beat_t qs[$];
    beat_t qf[$];
    int    n_cmp = 0;
    int    n_err = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .ZERO_MASK(MASK), .SKID(1'b1)) u_skid (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data), .out_ctrl(s_out_ctrl),
        .occupancy(s_occ)
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .ZERO_MASK(MASK), .SKID(1'b0)) u_flow (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(f_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(f_out_valid), .out_ready(out_ready), .out_data(f_out_data), .out_ctrl(f_out_ctrl),
        .occupancy(f_occ)
    );

    // One clock: score deliveries and acceptances at the negedge, then return just after the posedge.
    task automatic cyc();
        beat_t obs;
        beat_t exp;
        @(negedge clk);
        if (reset !== 1'b1 && (s_out_valid & out_ready) === 1'b1) begin
            obs = {s_out_data, s_out_ctrl};
            if (qs.size() > 0) exp = qs.pop_front(); else exp = 'x;
            n_cmp++;
            if (obs !== exp) begin n_err++; $display("FAIL sb_skid: got %h want %h", obs, exp); end
        end
        if (reset === 1'b1 || flush === 1'b1) qs.delete();
        else if ((in_valid & s_in_ready) === 1'b1) qs.push_back({in_data, in_ctrl});
        if (reset !== 1'b1 && (f_out_valid & out_ready) === 1'b1) begin
            obs = {f_out_data, f_out_ctrl};
            if (qf.size() > 0) exp = qf.pop_front(); else exp = 'x;
            n_cmp++;
            if (obs !== exp) begin n_err++; $display("FAIL sb_flow: got %h want %h", obs, exp); end
        end
        if (reset === 1'b1 || flush === 1'b1) qf.delete();
        else if ((in_valid & f_in_ready) === 1'b1) qf.push_back({in_data, in_ctrl});
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_data = '0; in_ctrl = '0;
        repeat (2) cyc();
        n_cmp++; if ({s_out_valid, s_out_data, s_out_ctrl, s_occ} !== '0) begin
            n_err++; $display("FAIL reset_skid_outs: got %b/%h/%h/%0d want all zero", s_out_valid, s_out_data, s_out_ctrl, s_occ); end
        n_cmp++; if ({f_out_valid, f_out_data, f_out_ctrl, f_occ} !== '0) begin
            n_err++; $display("FAIL reset_flow_outs: got %b/%h/%h/%0d want all zero", f_out_valid, f_out_data, f_out_ctrl, f_occ); end
        n_cmp++; if ({s_in_ready, f_in_ready} !== 2'b00) begin
            n_err++; $display("FAIL reset_in_ready: got %b%b want 00", s_in_ready, f_in_ready); end
        reset = 1'b0;
        #1;
        n_cmp++; if ({s_in_ready, f_in_ready} !== 2'b11) begin
            n_err++; $display("FAIL post_reset_in_ready: got %b%b want 11", s_in_ready, f_in_ready); end
    endtask

    task automatic test_drain(input string tag);
        idle();
        repeat (4) cyc();
        n_cmp++; if (qs.size() != 0 || qf.size() != 0) begin
            n_err++; $display("FAIL %s_drain: left %0d/%0d beats want 0/0", tag, qs.size(), qf.size()); end
        n_cmp++; if ({s_out_valid, f_out_valid, s_occ, f_occ} !== 6'b0) begin
            n_err++; $display("FAIL %s_empty: valid %b%b occ %0d/%0d want 00 0/0", tag, s_out_valid, f_out_valid, s_occ, f_occ); end
    endtask

    task automatic test_stream();
        logic [DW-1:0] v;
        idle();
        for (int i = 0; i < 8; i++) begin
            v = DW'(32'hC011 + i);
            in_valid = 1'b1; in_data = v; in_ctrl = CW'(32'h100 + i);
            cyc();
            n_cmp++; if (s_out_data !== v || s_occ !== 2'd1 || s_out_valid !== 1'b1) begin
                n_err++; $display("FAIL stream_skid[%0d]: got %h occ %0d want %h occ 1", i, s_out_data, s_occ, v); end
            n_cmp++; if (f_out_data !== v || f_occ !== 2'd1) begin
                n_err++; $display("FAIL stream_flow[%0d]: got %h occ %0d want %h occ 1", i, f_out_data, f_occ, v); end
        end
    endtask

    task automatic test_skid_absorb();
        logic [DW-1:0] tbl [3];
        logic          fire;
        int            k = 0;
        tbl[0] = 16'h00A1; tbl[1] = 16'h00A2; tbl[2] = 16'h00A3;
        idle();
        for (int t = 0; t < 8; t++) begin
            out_ready = (t >= 4);
            in_valid  = (k < 3);
            in_data   = tbl[(k < 3) ? k : 2];
            in_ctrl   = CW'(in_data);
            #1;
            fire = in_valid & s_in_ready;
            cyc();
            if (t == 2 || t == 3) begin
                n_cmp++; if (s_occ !== 2'd2 || s_in_ready !== 1'b0 || s_out_data !== 16'h00A1) begin
                    n_err++; $display("FAIL absorb_full[%0d]: occ %0d rdy %b head %h want 2 0 00a1", t, s_occ, s_in_ready, s_out_data); end
            end
            if (t <= 5) begin
                n_cmp++; if (s_out_valid !== 1'b1) begin
                    n_err++; $display("FAIL absorb_gap[%0d]: out_valid %b want 1", t, s_out_valid); end
            end
            if (fire) k++;
        end
    endtask

    task automatic test_noskid_stall();
        idle();
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 16'h0E01; in_ctrl = 10'h001;
        cyc();
        in_data = 16'h0E02; in_ctrl = 10'h002;
        cyc();
        n_cmp++; if (f_in_ready !== 1'b0 || f_out_data !== 16'h0E01) begin
            n_err++; $display("FAIL stall_hold: rdy %b head %h want 0 0e01", f_in_ready, f_out_data); end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (f_in_ready !== 1'b1) begin
            n_err++; $display("FAIL stall_release_rdy: got %b want 1", f_in_ready); end
        cyc();
        n_cmp++; if (f_out_valid !== 1'b1 || f_out_data !== 16'h0E02) begin
            n_err++; $display("FAIL stall_replace: valid %b head %h want 1 0e02", f_out_valid, f_out_data); end
    endtask

    task automatic test_flush_full();
        idle();
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 10'h3FF;
        in_data = 16'h5AD1; cyc();
        in_data = 16'h5AD2; cyc();
        n_cmp++; if (s_occ !== 2'd2) begin
            n_err++; $display("FAIL flush_setup_occ: got %0d want 2", s_occ); end
        flush = 1'b1; in_data = 16'h7BB0;
        #1;
        n_cmp++; if (s_in_ready !== 1'b1 || f_in_ready !== 1'b1) begin
            n_err++; $display("FAIL flush_in_ready: got %b%b want 11", s_in_ready, f_in_ready); end
        cyc();
        n_cmp++; if ({s_out_valid, s_out_ctrl, s_occ} !== '0 || s_out_data !== 16'h00D1) begin
            n_err++; $display("FAIL flush_skid: valid %b ctrl %h occ %0d data %h want 0 0 0 00d1", s_out_valid, s_out_ctrl, s_occ, s_out_data); end
        n_cmp++; if ({f_out_valid, f_out_ctrl, f_occ} !== '0 || f_out_data !== 16'h00D1) begin
            n_err++; $display("FAIL flush_flow: valid %b ctrl %h occ %0d data %h want 0 0 0 00d1", f_out_valid, f_out_ctrl, f_occ, f_out_data); end
        flush = 1'b0; out_ready = 1'b1; in_data = 16'h1234; in_ctrl = 10'h055;
        cyc();
        n_cmp++; if (s_out_valid !== 1'b1 || s_out_data !== 16'h1234 || f_out_data !== 16'h1234) begin
            n_err++; $display("FAIL flush_next_beat: valid %b data %h/%h want 1 1234", s_out_valid, s_out_data, f_out_data); end
        flush = 1'b1; in_valid = 1'b0;
        cyc();
        n_cmp++; if (s_out_valid !== 1'b0 || f_out_valid !== 1'b0) begin
            n_err++; $display("FAIL flush_deliver: valid %b%b want 00", s_out_valid, f_out_valid); end
    endtask

    task automatic test_reset_mid(input logic with_flush);
        idle();
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 10'h2AA;
        in_data = 16'h0D01; cyc();
        in_data = 16'h0D02; cyc();
        n_cmp++; if (s_occ !== 2'd2) begin
            n_err++; $display("FAIL rst%b_setup_occ: got %0d want 2", with_flush, s_occ); end
        reset = 1'b1; flush = with_flush; in_data = 16'h0DB0;
        #1;
        n_cmp++; if (s_in_ready !== 1'b0 || f_in_ready !== 1'b0) begin
            n_err++; $display("FAIL rst%b_in_ready: got %b%b want 00", with_flush, s_in_ready, f_in_ready); end
        cyc();
        n_cmp++; if ({s_out_valid, s_out_data, s_out_ctrl, s_occ, f_out_valid, f_out_data, f_out_ctrl, f_occ} !== '0) begin
            n_err++; $display("FAIL rst%b_outs: got %b %h %h %0d / %b %h %h %0d want zeros", with_flush,
                              s_out_valid, s_out_data, s_out_ctrl, s_occ, f_out_valid, f_out_data, f_out_ctrl, f_occ); end
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
        #1;
        n_cmp++; if (s_in_ready !== 1'b1 || f_in_ready !== 1'b1) begin
            n_err++; $display("FAIL rst%b_after: in_ready %b%b want 11", with_flush, s_in_ready, f_in_ready); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_drain("stream");
        test_skid_absorb();
        test_drain("absorb");
        test_noskid_stall();
        test_drain("stall");
        test_flush_full();
        test_drain("flush");
        test_reset_mid(1'b0);
        test_drain("reset_mid");
        test_reset_mid(1'b1);
        test_drain("flush_reset");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register for the MIPS datapath. It replaces the hard-wired stage latches with one block that carries a generic payload, converts in-flight entries to NOPs on flush, and adds a valid/ready handshake. An optional 2-entry skid buffer gives full throughput with a registered `in_ready`. One instance sits between each pair of adjacent stages (IF/ID, ID/EX, EX/MEM, MEM/WB); the hazard unit drives `out_ready` and `flush`.

## Interface
- `DATA_W`, default 128: payload bits (PC+4, operands, immediate, register numbers, IO/halt flags).
- `CTRL_W`, default 10: control bits (EX/MEM/WB fields); all-zero encodes NOP.
- `ZERO_MASK`, default all zeros, `DATA_W` bits: payload bits forced to 0 on flush. Example: operand fields, so flushed ALU ops cannot overflow.
- `SKID`, default 1: 1 selects a 2-entry skid buffer with registered `in_ready`; 0 selects a 1-entry register with combinational `in_ready`.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `flush` in 1: squash every entry held in the stage and the beat offered this cycle.
- `in_valid` in 1: upstream beat valid.
- `in_ready` out 1: stage can accept a beat.
- `in_data` in `DATA_W`: payload.
- `in_ctrl` in `CTRL_W`: control.
- `out_valid` out 1: head entry valid.
- `out_ready` in 1: downstream accepts; driven low to stall.
- `out_data` out `DATA_W`: head payload.
- `out_ctrl` out `CTRL_W`: head control; 0 whenever `out_valid`=0.
- `occupancy` out 2: entries held, 0..2.

## Operation
- The handshake completes only when valid and ready are both high. `in_fire`=`in_valid & in_ready`; `out_fire`=`out_valid & out_ready`.
- Occupancy states are EMPTY(0), ONE(1) and TWO(2). TWO exists only when `SKID`=1.
  - EMPTY: `in_fire` goes to ONE.
  - ONE: `in_fire & !out_fire` goes to TWO when `SKID`=1. That combination cannot occur when `SKID`=0. `in_fire & out_fire` stays in ONE with the head replaced. `out_fire` alone goes to EMPTY.
  - TWO: `out_fire` moves the skid entry to the head and goes to ONE. `in_ready`=0 in TWO.
- Order is strictly FIFO, with no duplication and no loss.
- `in_ready` rules:
  - `SKID`=1: `in_ready` is registered and equals `state != TWO`.
  - `SKID`=0: `in_ready` = `!out_valid | out_ready`.
  - Both modes: `in_ready` is forced to 1 during `flush` and forced to 0 while `reset`=1.
- Flush has priority over every handshake:
  - The next state is EMPTY, `out_valid`=0 and `out_ctrl`=0.
  - Payload bits selected by `ZERO_MASK` are cleared; all other payload bits keep their last value.
  - An input beat offered in the same cycle is consumed (`in_fire`=1) and discarded.
  - `out_fire` in the same cycle still counts as delivered downstream.
- `reset` overrides `flush`. All state and outputs go to 0.
- `occupancy` reflects the state register.

## Timing
- Latency: 1 cycle from `in_fire` to `out_valid`.
- Throughput: 1 beat/cycle while `out_ready`=1, in both modes.
- Reset values: `out_valid`=0, `out_data`=0, `out_ctrl`=0, `occupancy`=0, `in_ready`=0 while reset is held. In the first cycle after reset, `in_ready`=1.
- Stall: when `out_ready` drops, `out_*` hold stable. In `SKID`=1 mode one further beat is absorbed and `in_ready` falls on the next edge.
- Flush: `out_valid`=0 on the edge after `flush`. A new beat accepted in the cycle after the flush appears one cycle later.

## Structure
- Shared package `pipe_pkg` holds:
  - `occ_t` enum: EMPTY=2'd0, ONE=2'd1, TWO=2'd2.
  - `CTRL_NOP` constant (all zeros).
- Sub-module `pipe_slot` is one data+ctrl+valid register with load, clear and mask-zero controls. It is instantiated once for the head and, when `SKID`=1, once for the skid entry.

## Test plan
- Streaming, `SKID`=1, `out_ready`=1: beats 0x11..0x18 in 8 back-to-back cycles produce the same 8 values one cycle later; `occupancy` stays at 1.
- Skid absorb: hold `out_ready`=0 while offering 0xA1, 0xA2, 0xA3. `occupancy` reaches 2, `in_ready`=0, and 0xA3 stays offered. Release `out_ready`: output order is A1, A2, A3 with no gaps.
- Flush while full: in state TWO with `in_ctrl`=0x3FF, assert `flush` with 0xB0 offered. Next cycle: `out_valid`=0, `out_ctrl`=0, masked payload bits=0, `occupancy`=0. 0xB0 never appears.
- `SKID`=0 stall: with the head held and `out_ready`=0, `in_ready`=0. Setting `out_ready`=1 with `in_valid`=1 raises `in_ready` in the same cycle and replaces the head on the next edge.
- Reset mid-stream: assert `reset` with 2 entries held. All outputs are 0 and `in_ready`=0 during reset; `in_ready`=1 the cycle after.
- Flush with reset high at the same time: reset values result, and no stale beat emerges.
